// File: rtl/bram_pkg.sv
// Shared definitions for the capture BRAM read/write paths.
//   BRAM_ADDR_SHIFT : word address -> byte address shift (byte-addressed BRAM port)
//   state_t         : reader FSM states
package bram_pkg;

  localparam int unsigned BRAM_ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en    : push din (ignored when full; the reader's credit scheme never does this)
//   din      : write data
//   rd_en    : pop the head entry (ignored when empty)
//   dout     : head entry, valid whenever empty=0
//   empty    : no entries held
//   full     : DEPTH entries held
//   count    : number of entries held, 0..DEPTH
module stream_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty = (cnt == '0);
    full  = (cnt == (AW+1)'(DEPTH));
    do_wr = wr_en && !full;
    do_rd = rd_en && !empty;
    dout  = mem[rd_ptr];
    count = cnt;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // The reader guarantees in_flight + count <= DEPTH, so a write into a full FIFO is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/bram_stream_reader.sv
// Read side of the capture BRAM: on a start pulse, reads num_words consecutive
// words from start_addr (wrapping mod 2^COUNT_WIDTH) and emits them on an
// AXI4-Stream master. The BRAM read latency is hidden by a credit-limited FIFO.
// Parameters: COUNT_WIDTH (word address width), DATA_WIDTH, READ_LATENCY (1 or 2),
//             FIFO_DEPTH (power of two, >= READ_LATENCY+2).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (deasserted synchronously inside)
//   start           : one-cycle request, honoured only in IDLE and not in the done cycle
//   start_addr      : first word address
//   num_words       : words to read, 0 = whole buffer
//   busy            : burst in progress
//   done            : one-cycle pulse after the final word handshakes
//   bram_addr       : byte address of the read (zero when no read is issued)
//   bram_en         : read strobe
//   bram_rdata      : read data, valid READ_LATENCY cycles after bram_en
//   m_axis_*        : stream master (tdata, tvalid, tready, tlast)
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH  = 14,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] start_addr,
  input  logic [COUNT_WIDTH-1:0] num_words,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            bram_addr,
  output logic                   bram_en,
  input  logic [DATA_WIDTH-1:0]  bram_rdata,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]              rst_pipe;
  logic                    rst_i;

  state_t                  state;
  state_t                  state_next;
  logic                    done_q;

  logic [COUNT_WIDTH-1:0]  word_addr;
  logic [COUNT_WIDTH-1:0]  addr_cur;
  logic [COUNT_WIDTH:0]    remaining;
  logic [COUNT_WIDTH:0]    rem_cur;
  logic [COUNT_WIDTH:0]    words_req;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          credit_sum;
  logic [READ_LATENCY-1:0] tag_pipe;
  logic [READ_LATENCY-1:0] last_pipe;

  logic                    accept;
  logic                    credit_ok;
  logic                    issue;
  logic                    last_issue;
  logic                    pop;
  logic                    last_pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [DATA_WIDTH:0]     fifo_dout;

  // Reset asserts asynchronously and releases two clocks after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= '1;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_i = rst_pipe[1];

  // The first read is issued in the accepting IDLE cycle straight from the
  // start inputs; the registered address/count then continue from the next word.
  always_comb begin
    words_req  = {(num_words == '0), num_words};
    accept     = (state == ST_IDLE) && start && !done_q;
    addr_cur   = (state == ST_IDLE) ? start_addr : word_addr;
    rem_cur    = (state == ST_IDLE) ? words_req : remaining;
    credit_sum = {1'b0, in_flight} + {1'b0, fifo_count};
    credit_ok  = !fifo_full && (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
    issue      = accept || ((state == ST_RUN) && credit_ok);
    last_issue = issue && (rem_cur == (COUNT_WIDTH+1)'(1));
    pop        = !fifo_empty && m_axis_tready;
    last_pop   = pop && fifo_dout[DATA_WIDTH];
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = last_issue ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if (last_pop) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy          = (state != ST_IDLE);
    done          = done_q;
    bram_en       = issue;
    bram_addr     = issue ? (32'(addr_cur) << BRAM_ADDR_SHIFT) : '0;
    m_axis_tvalid = !fifo_empty;
    m_axis_tdata  = fifo_dout[DATA_WIDTH-1:0];
    m_axis_tlast  = fifo_dout[DATA_WIDTH] && !fifo_empty;
  end

  // Address/remaining counters, read-latency tags and read credits.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      word_addr <= '0;
      remaining <= '0;
      in_flight <= '0;
      tag_pipe  <= '0;
      last_pipe <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == ST_DRAIN) && last_pop;
      if (issue) begin
        word_addr <= addr_cur + 1'b1;
        remaining <= rem_cur - 1'b1;
      end
      case ({issue, tag_pipe[READ_LATENCY-1]})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
      tag_pipe[0]  <= issue;
      last_pipe[0] <= last_issue;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i]  <= tag_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  stream_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_i),
    .wr_en (tag_pipe[READ_LATENCY-1]),
    .din   ({last_pipe[READ_LATENCY-1], bram_rdata}),
    .rd_en (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int unsigned CW     = 5;
  localparam int unsigned DW     = 32;
  localparam int unsigned RL     = 2;
  localparam int unsigned FD     = 4;
  localparam int unsigned NWORDS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] start_addr;
  logic [CW-1:0] num_words;
  logic          busy;
  logic          done;
  logic [31:0]   bram_addr;
  logic          bram_en;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [DW-1:0] mem [NWORDS];
  logic [DW-1:0] pipe1;

  typedef struct {
    int unsigned sa;
    int unsigned nw;
    int unsigned pct;
    int unsigned poke;
    int unsigned exp_n;
    logic [31:0] exp_a0;
    logic [31:0] exp_alast;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  // Two-stage registered BRAM read port (READ_LATENCY = 2).
  always @(posedge clk) begin
    pipe1      <= mem[bram_addr[CW+1:2]];
    bram_rdata <= pipe1;
  end

  bram_stream_reader #(
    .COUNT_WIDTH  (CW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_addr    (start_addr),
    .num_words     (num_words),
    .busy          (busy),
    .done          (done),
    .bram_addr     (bram_addr),
    .bram_en       (bram_en),
    .bram_rdata    (bram_rdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_burst(input string tag, input int unsigned sa, input int unsigned nw,
                          input int unsigned pct, input int unsigned poke,
                          input int unsigned exp_n, input logic [31:0] exp_a0,
                          input logic [31:0] exp_alast);
    logic [31:0] addrs [$];
    logic [DW:0] words [$];
    logic [DW:0] held;
    logic        stall = 1'b0;
    logic        busy_k1 = 1'b0;
    int          first_v = -1;
    int          last_hs = -1;
    int          done_k  = -1;
    int unsigned en_cnt = 0;
    int unsigned stab_err = 0;
    int unsigned data_err = 0;
    int unsigned addr_err = 0;
    int unsigned quiet = 0;
    int unsigned widx;

    @(negedge clk);
    m_axis_tready = 1'b0;
    start = 1'b1; start_addr = CW'(sa); num_words = CW'(nw);
    #1;
    if (bram_en) begin en_cnt++; addrs.push_back(bram_addr); end
    @(posedge clk);
    #1;
    start = 1'b0; start_addr = CW'($urandom); num_words = CW'($urandom);

    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      m_axis_tready = ($urandom_range(99) < pct);
      if (k == 1) busy_k1 = busy;
      if (bram_en) begin en_cnt++; addrs.push_back(bram_addr); end
      if (m_axis_tvalid) begin
        if (first_v < 0) first_v = k;
        if (stall && ({m_axis_tlast, m_axis_tdata} !== held)) stab_err++;
        if (m_axis_tready) begin
          words.push_back({m_axis_tlast, m_axis_tdata});
          last_hs = k;
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tlast, m_axis_tdata};
      if (done) begin done_k = k; break; end
      if (poke != 0 && k == 2) begin
        start = 1'b1; start_addr = CW'(sa + 9); num_words = CW'(nw + 3);
      end
    end

    chk({tag, ":done_seen"}, 64'(done_k > 0), 64'd1);
    if (poke != 0 && done_k > 0) begin
      start = 1'b1; start_addr = CW'(sa + 1); num_words = 5'd2;
      #1;
      if (bram_en) quiet++;
      @(posedge clk);
      #1 start = 1'b0;
    end
    repeat (8) begin
      @(negedge clk);
      if (bram_en || busy || done || m_axis_tvalid) quiet++;
    end

    for (int unsigned i = 0; i < words.size(); i++) begin
      widx = (sa + i) % NWORDS;
      if (words[i] !== {(i == exp_n - 1), mem[widx]}) data_err++;
    end
    for (int unsigned i = 0; i < addrs.size(); i++) begin
      if (addrs[i] !== 32'(((sa + i) % NWORDS) * 4)) addr_err++;
    end

    chk({tag, ":busy"}, 64'(busy_k1), 64'd1);
    chk({tag, ":word_count"}, 64'(words.size()), 64'(exp_n));
    chk({tag, ":data_tlast"}, 64'(data_err), 64'd0);
    chk({tag, ":en_count"}, 64'(en_cnt), 64'(exp_n));
    chk({tag, ":addr_seq"}, 64'(addr_err), 64'd0);
    chk({tag, ":addr_first"}, 64'((addrs.size() > 0) ? addrs[0] : 32'hFFFF_FFFF), 64'(exp_a0));
    chk({tag, ":addr_last"}, 64'((addrs.size() > 0) ? addrs[addrs.size()-1] : 32'hFFFF_FFFF),
        64'(exp_alast));
    chk({tag, ":first_valid"}, 64'(first_v), 64'(RL + 1));
    chk({tag, ":done_timing"}, 64'(done_k), 64'(last_hs + 1));
    chk({tag, ":stable"}, 64'(stab_err), 64'd0);
    chk({tag, ":quiet_after"}, 64'(quiet), 64'd0);
    if (pct >= 100) chk({tag, ":throughput"}, 64'(last_hs - first_v), 64'(exp_n - 1));
  endtask

  initial begin
    int unsigned hs;
    int unsigned q;
    int unsigned rsa, rnw, rn;

    vecs[0] = '{sa: 0,  nw: 8,  pct: 100, poke: 0, exp_n: 8,  exp_a0: 32'h00, exp_alast: 32'h1C};
    vecs[1] = '{sa: 30, nw: 4,  pct: 100, poke: 0, exp_n: 4,  exp_a0: 32'h78, exp_alast: 32'h04};
    vecs[2] = '{sa: 0,  nw: 0,  pct: 100, poke: 0, exp_n: 32, exp_a0: 32'h00, exp_alast: 32'h7C};
    vecs[3] = '{sa: 5,  nw: 0,  pct: 30,  poke: 0, exp_n: 32, exp_a0: 32'h14, exp_alast: 32'h10};
    vecs[4] = '{sa: 10, nw: 6,  pct: 100, poke: 1, exp_n: 6,  exp_a0: 32'h28, exp_alast: 32'h3C};
    vecs[5] = '{sa: 31, nw: 1,  pct: 50,  poke: 1, exp_n: 1,  exp_a0: 32'h7C, exp_alast: 32'h7C};
    vecs[6] = '{sa: 17, nw: 13, pct: 70,  poke: 0, exp_n: 13, exp_a0: 32'h44, exp_alast: 32'h74};

    for (int unsigned i = 0; i < NWORDS; i++) mem[i] = $urandom;

    rst = 1'b1; start = 1'b0; start_addr = '0; num_words = '0; m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:done", 64'(done), 64'd0);
    chk("reset:bram_en", 64'(bram_en), 64'd0);
    chk("reset:tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset:tlast", 64'(m_axis_tlast), 64'd0);
    chk("reset:bram_addr", 64'(bram_addr), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int unsigned i = 0; i < 7; i++) begin
      do_burst($sformatf("vec%0d", i), vecs[i].sa, vecs[i].nw, vecs[i].pct, vecs[i].poke,
               vecs[i].exp_n, vecs[i].exp_a0, vecs[i].exp_alast);
    end

    for (int unsigned i = 0; i < 6; i++) begin
      rsa = $urandom_range(NWORDS - 1);
      rnw = $urandom_range(NWORDS - 1);
      rn  = (rnw == 0) ? NWORDS : rnw;
      do_burst($sformatf("rnd%0d", i), rsa, rnw, $urandom_range(100, 20), $urandom_range(1),
               rn, 32'(rsa * 4), 32'(((rsa + rn - 1) % NWORDS) * 4));
    end

    // Abort a 20-word burst right after its fifth word, then run a fresh one.
    @(negedge clk);
    m_axis_tready = 1'b1;
    start = 1'b1; start_addr = 5'd2; num_words = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    hs = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) hs++;
      if (hs == 5) break;
    end
    chk("abort:reached_word5", 64'(hs), 64'd5);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort:tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("abort:busy", 64'(busy), 64'd0);
    chk("abort:bram_en", 64'(bram_en), 64'd0);
    chk("abort:tlast", 64'(m_axis_tlast), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    q = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || m_axis_tvalid || busy || bram_en) q++;
    end
    chk("abort:no_done", 64'(q), 64'd0);
    do_burst("fresh", 7, 3, 100, 0, 3, 32'h1C, 32'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
